// File: rtl/eye_pkg.sv
// Shared types and default tuning constants for the eye openness tracker.
package eye_pkg;

    typedef enum logic [2:0] {
        ST_CAL,
        ST_READY,
        ST_FILT,
        ST_DIV,
        ST_OUT
    } tracker_state_t;

    localparam int DEF_EMA_SHIFT  = 2;
    localparam int DEF_BLINK_LOW  = 64;
    localparam int DEF_BLINK_HIGH = 96;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing one quotient bit per cycle for a fixed Q_W cycles.
// done is high during the final iteration; quotient is stable from the following cycle.
module seq_divider #(
    parameter int NUM_W = 24,
    parameter int DEN_W = 16,
    parameter int Q_W   = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start,
    input  logic             abort,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CNT_W = $clog2(Q_W + 1);

    logic [DEN_W-1:0] rem_r;
    logic [DEN_W-1:0] den_r;
    logic [Q_W-1:0]   low_r;
    logic [Q_W-1:0]   q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             den_zero_r;
    logic [DEN_W:0]   trial;
    logic             take;

    // The numerator's upper DEN_W bits are already below den, so only Q_W bits remain to resolve.
    assign trial    = {rem_r, low_r[Q_W-1]};
    assign take     = trial >= {1'b0, den_r};
    assign done     = (cnt_r == CNT_W'(1));
    assign quotient = den_zero_r ? '1 : q_r;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rem_r      <= '0;
            den_r      <= '0;
            low_r      <= '0;
            q_r        <= '0;
            cnt_r      <= '0;
            den_zero_r <= 1'b0;
        end else if (abort) begin
            cnt_r <= '0;
        end else if (start) begin
            rem_r      <= num[Q_W +: DEN_W];
            low_r      <= num[Q_W-1:0];
            den_r      <= den;
            den_zero_r <= (den == '0);
            q_r        <= '0;
            cnt_r      <= CNT_W'(Q_W);
        end else if (cnt_r != '0) begin
            rem_r <= take ? DEN_W'(trial - {1'b0, den_r}) : trial[DEN_W-1:0];
            low_r <= low_r << 1;
            q_r   <= {q_r[Q_W-2:0], take};
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

endmodule

// File: rtl/eye_openness_tracker.sv
// Calibrates min/max openness, smooths with a shift-EMA, normalises to OUT_WIDTH bits
// and derives a debounced, hysteretic blink flag.
module eye_openness_tracker
    import eye_pkg::*;
#(
    parameter int LOG_FACE_RES = 16,
    parameter int OUT_WIDTH    = 8,
    parameter int EMA_SHIFT    = DEF_EMA_SHIFT,
    parameter int CAL_SAMPLES  = 16,
    parameter int BLINK_LOW    = DEF_BLINK_LOW,
    parameter int BLINK_HIGH   = DEF_BLINK_HIGH,
    parameter int DEBOUNCE     = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    calibrate_in,
    input  logic                    eye_valid_in,
    input  logic [LOG_FACE_RES-1:0] eye_openness_in,
    input  logic [15:0]             eye_pupil_in,
    output logic                    ready_out,
    output logic                    level_valid_out,
    output logic [OUT_WIDTH-1:0]    level_out,
    output logic                    blink_out,
    output logic                    calibrated_out,
    output logic                    dropped_out
);

    localparam int EMA_W = LOG_FACE_RES + 1;
    localparam int NUM_W = LOG_FACE_RES + OUT_WIDTH;
    localparam int CAL_W = $clog2(CAL_SAMPLES + 1);
    localparam int LOW_W = $clog2(DEBOUNCE + 1);
    localparam logic [NUM_W-1:0]     LEVEL_MAX    = NUM_W'((1 << OUT_WIDTH) - 1);
    localparam logic [OUT_WIDTH-1:0] BLINK_LOW_V  = OUT_WIDTH'(BLINK_LOW);
    localparam logic [OUT_WIDTH-1:0] BLINK_HIGH_V = OUT_WIDTH'(BLINK_HIGH);

    tracker_state_t           state_r;
    logic [LOG_FACE_RES-1:0]  min_r;
    logic [LOG_FACE_RES-1:0]  max_r;
    logic [LOG_FACE_RES-1:0]  sample_r;
    logic signed [EMA_W-1:0]  ema_r;
    logic                     first_r;
    logic [CAL_W-1:0]         cal_cnt_r;
    logic [LOW_W-1:0]         low_cnt_r;

    logic                     accept;
    logic signed [EMA_W-1:0]  x_s;
    logic signed [EMA_W-1:0]  delta;
    logic signed [EMA_W-1:0]  ema_next;
    logic [LOG_FACE_RES-1:0]  ema_c;
    logic [LOG_FACE_RES-1:0]  span;
    logic [NUM_W-1:0]         div_num;
    logic [LOG_FACE_RES-1:0]  div_den;
    logic                     div_start;
    logic                     div_done;
    logic [OUT_WIDTH-1:0]     div_q;
    logic [LOW_W-1:0]         low_next;

    assign ready_out = (state_r == ST_CAL) || (state_r == ST_READY);
    assign accept    = eye_valid_in && ready_out && (eye_pupil_in != 16'd0) && !calibrate_in;
    assign div_start = (state_r == ST_FILT) && !calibrate_in;
    assign low_next  = (low_cnt_r == LOW_W'(DEBOUNCE)) ? low_cnt_r : low_cnt_r + LOW_W'(1);

    // The stored EMA stays unclamped; only the value fed to the divider is limited to the calibrated range.
    always_comb begin
        x_s      = $signed({1'b0, sample_r});
        delta    = (x_s - ema_r) >>> EMA_SHIFT;
        ema_next = first_r ? x_s : ema_r + delta;
        if (ema_next < $signed({1'b0, min_r})) begin
            ema_c = min_r;
        end else if (ema_next > $signed({1'b0, max_r})) begin
            ema_c = max_r;
        end else begin
            ema_c = ema_next[LOG_FACE_RES-1:0];
        end
        span    = ema_c - min_r;
        div_den = max_r - min_r;
        div_num = NUM_W'(span) * LEVEL_MAX;
    end

    seq_divider #(
        .NUM_W(NUM_W),
        .DEN_W(LOG_FACE_RES),
        .Q_W  (OUT_WIDTH)
    ) u_div (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .start   (div_start),
        .abort   (calibrate_in),
        .num     (div_num),
        .den     (div_den),
        .done    (div_done),
        .quotient(div_q)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r         <= ST_CAL;
            min_r           <= '1;
            max_r           <= '0;
            sample_r        <= '0;
            ema_r           <= '0;
            first_r         <= 1'b0;
            cal_cnt_r       <= '0;
            low_cnt_r       <= '0;
            level_valid_out <= 1'b0;
            level_out       <= '0;
            blink_out       <= 1'b0;
            calibrated_out  <= 1'b0;
            dropped_out     <= 1'b0;
        end else begin
            level_valid_out <= 1'b0;
            if (calibrate_in) begin
                state_r        <= ST_CAL;
                min_r          <= '1;
                max_r          <= '0;
                cal_cnt_r      <= '0;
                low_cnt_r      <= '0;
                first_r        <= 1'b0;
                calibrated_out <= 1'b0;
                blink_out      <= 1'b0;
                dropped_out    <= 1'b0;
            end else begin
                if (eye_valid_in && !ready_out) begin
                    dropped_out <= 1'b1;
                end
                unique case (state_r)
                    ST_CAL: begin
                        if (accept) begin
                            if (eye_openness_in < min_r) min_r <= eye_openness_in;
                            if (eye_openness_in > max_r) max_r <= eye_openness_in;
                            cal_cnt_r <= cal_cnt_r + CAL_W'(1);
                            if (cal_cnt_r == CAL_W'(CAL_SAMPLES - 1)) begin
                                calibrated_out <= 1'b1;
                                first_r        <= 1'b1;
                                state_r        <= ST_READY;
                            end
                        end
                    end
                    ST_READY: begin
                        if (accept) begin
                            sample_r <= eye_openness_in;
                            state_r  <= ST_FILT;
                        end
                    end
                    ST_FILT: begin
                        ema_r   <= ema_next;
                        first_r <= 1'b0;
                        state_r <= ST_DIV;
                    end
                    ST_DIV: begin
                        if (div_done) state_r <= ST_OUT;
                    end
                    ST_OUT: begin
                        level_out       <= div_q;
                        level_valid_out <= 1'b1;
                        state_r         <= ST_READY;
                        if (div_q < BLINK_LOW_V) begin
                            low_cnt_r <= low_next;
                            if (low_next >= LOW_W'(DEBOUNCE)) blink_out <= 1'b1;
                        end else if (div_q > BLINK_HIGH_V) begin
                            low_cnt_r <= '0;
                            blink_out <= 1'b0;
                        end else begin
                            low_cnt_r <= '0;
                        end
                    end
                    default: state_r <= ST_CAL;
                endcase
            end
        end
    end

endmodule
